// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the capture-RAM controller: state encoding and
// default geometry.
package ram_ctrl_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_FULL  = 2'd2;
  localparam state_t ST_READ  = 2'd3;

endpackage

// File: rtl/ram_ctrl_fsm_addr_ctr.sv
// Modulo-DEPTH address counter with synchronous clear, load and increment.
// Priority: reset > clear > load > increment.
module addr_ctr
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next count; increment wraps at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_ctrl_fsm.sv
// Capture-RAM controller: fills a DEPTH-word RAM one-shot or circularly,
// parks in FULL, then reads the captured words back oldest-first.
module ram_ctrl_fsm
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_write_full,
  input  logic              i_mode,
  input  logic              i_read_req,
  output logic              o_write_ena,
  output logic              o_read_ena,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_full_mem_indicator,
  output logic [ADDR_W:0]   o_fill_cnt,
  output logic              o_busy
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   rd_rem_q, rd_rem_d;
  logic               wrapped_q, wrapped_d;
  logic               mode_q, mode_d;

  logic               write_ena_q, read_ena_q, full_q, busy_q;

  logic               ctr_clr, ctr_load, ctr_inc;
  logic [ADDR_W-1:0]  ctr_load_val;
  logic [ADDR_W-1:0]  addr;
  logic               addr_last;

  assign addr_last = (addr == LAST);

  // Address generator for both write and read phases.
  addr_ctr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk        (clk),
    .rst_i      (i_rst),
    .clr_i      (ctr_clr),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .inc_i      (ctr_inc),
    .cnt_o      (addr)
  );

  // Next-state, counter and address-control logic.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    rd_rem_d     = rd_rem_q;
    wrapped_d    = wrapped_q;
    mode_d       = mode_q;
    ctr_clr      = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_WRITE;
          ctr_clr   = 1'b1;
          fill_d    = '0;
          wrapped_d = 1'b0;
          mode_d    = i_mode;
        end
      end

      ST_WRITE: begin
        // The current word is always written; the address still advances
        // on exit so FULL holds the next write address (oldest word).
        ctr_inc = 1'b1;
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + CNT_W'(1);
        if (i_write_full) begin
          state_d = ST_FULL;
        end else if (addr_last) begin
          if (mode_q) begin
            wrapped_d = 1'b1;
          end else begin
            state_d = ST_FULL;
          end
        end
      end

      ST_FULL: begin
        if (i_read_req) begin
          state_d      = ST_READ;
          ctr_load     = 1'b1;
          ctr_load_val = wrapped_q ? addr : '0;
          rd_rem_d     = fill_q;
        end
      end

      ST_READ: begin
        if (rd_rem_q == CNT_W'(1)) begin
          state_d  = ST_IDLE;
          ctr_clr  = 1'b1;
          rd_rem_d = '0;
        end else begin
          rd_rem_d = rd_rem_q - CNT_W'(1);
          ctr_inc  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ctr_clr = 1'b1;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      fill_q    <= '0;
      rd_rem_q  <= '0;
      wrapped_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      rd_rem_q  <= rd_rem_d;
      wrapped_q <= wrapped_d;
      mode_q    <= mode_d;
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      write_ena_q <= 1'b0;
      read_ena_q  <= 1'b0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      write_ena_q <= (state_d == ST_WRITE);
      read_ena_q  <= (state_d == ST_READ);
      full_q      <= (state_d == ST_FULL);
      busy_q      <= (state_d == ST_WRITE) || (state_d == ST_READ);
    end
  end

  assign o_write_ena          = write_ena_q;
  assign o_read_ena           = read_ena_q;
  assign o_addr               = addr;
  assign o_full_mem_indicator = full_q;
  assign o_fill_cnt           = fill_q;
  assign o_busy               = busy_q;

endmodule

// File: tb/tb_ram_ctrl_fsm.sv
// Scoreboard bench for ram_ctrl_fsm: the driver pushes the expected write,
// FULL and read events of each capture; a monitor pops and compares.
module tb_ram_ctrl_fsm;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam int K_WRITE = 0;
  localparam int K_READ  = 1;
  localparam int K_FULL  = 2;

  logic              clk = 1'b0;
  logic              i_rst, i_start, i_write_full, i_mode, i_read_req;
  logic              o_write_ena, o_read_ena, o_full_mem_indicator, o_busy;
  logic [ADDR_W-1:0] o_addr;
  logic [ADDR_W:0]   o_fill_cnt;

  typedef struct {
    int kind;
    int addr;
    int fill;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   prev_full = 1'b0;

  ram_ctrl_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .i_rst                (i_rst),
    .i_start              (i_start),
    .i_write_full         (i_write_full),
    .i_mode               (i_mode),
    .i_read_req           (i_read_req),
    .o_write_ena          (o_write_ena),
    .o_read_ena           (o_read_ena),
    .o_addr               (o_addr),
    .o_full_mem_indicator (o_full_mem_indicator),
    .o_fill_cnt           (o_fill_cnt),
    .o_busy               (o_busy)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    return (k == K_WRITE) ? "write" : (k == K_READ) ? "read" : "full";
  endfunction

  task automatic push(input int kind, input int addr, input int fill);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.fill = fill;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got addr=%0d fill=%0d, expected no event",
               kname(kind), o_addr, o_fill_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || int'(o_addr) != e.addr ||
          (kind == K_FULL && int'(o_fill_cnt) != e.fill)) begin
        errors++;
        $display("FAIL %s_event: got %s addr=%0d fill=%0d, expected %s addr=%0d fill=%0d",
                 kname(kind), kname(kind), o_addr, o_fill_cnt,
                 kname(e.kind), e.addr, e.fill);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (o_write_ena !== 1'b0 || o_read_ena !== 1'b0 || o_addr !== '0 ||
        o_full_mem_indicator !== 1'b0 || o_fill_cnt !== '0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got we=%b re=%b addr=%0d full=%b fill=%0d busy=%b, expected all 0",
               name, o_write_ena, o_read_ena, o_addr, o_full_mem_indicator,
               o_fill_cnt, o_busy);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (o_write_ena !== 1'b0 || o_read_ena !== 1'b0 ||
        o_full_mem_indicator !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got we=%b re=%b full=%b busy=%b, expected 0 0 0 0",
               name, o_write_ena, o_read_ena, o_full_mem_indicator, o_busy);
    end
  endtask

  // Monitor: per-cycle sanity plus scoreboard pops on each visible event.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (o_write_ena && o_read_ena) begin
        errors++;
        $display("FAIL strobe_excl: got we=1 re=1, expected at most one");
      end
      checks++;
      if (o_busy !== (o_write_ena | o_read_ena)) begin
        errors++;
        $display("FAIL busy: got %b, expected %b", o_busy, o_write_ena | o_read_ena);
      end
      if (o_write_ena) pop_check(K_WRITE);
      if (o_read_ena)  pop_check(K_READ);
      if (o_full_mem_indicator && !prev_full) pop_check(K_FULL);
    end
    prev_full = o_full_mem_indicator;
  end

  // One capture + readback. stop_k: write cycle (1-based) on which
  // i_write_full is raised, 0 for none. rst_at_read: read cycle on which
  // reset is pulsed, 0 for a full readback.
  task automatic capture(input bit mode, input int stop_k, input int rst_at_read);
    int n, fill, start, nreads, last, hold;
    if (mode) n = stop_k;
    else      n = (stop_k == 0 || stop_k > DEPTH) ? DEPTH : stop_k;
    fill  = (n < DEPTH) ? n : DEPTH;
    start = (n > DEPTH) ? (n % DEPTH) : 0;
    last  = (stop_k > n) ? stop_k : n;

    for (int k = 0; k < n; k++) push(K_WRITE, k % DEPTH, 0);
    push(K_FULL, n % DEPTH, fill);

    @(negedge clk);
    i_mode  = mode;
    i_start = 1'b1;
    @(negedge clk);
    i_mode  = 1'($urandom_range(1, 0));
    for (int j = 1; j <= last; j++) begin
      i_write_full = (j == stop_k);
      i_start      = 1'($urandom_range(1, 0));
      i_read_req   = (j <= n) ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
    end
    i_write_full = 1'b0;
    i_start      = 1'b0;
    i_read_req   = 1'b0;

    // Out-of-state inputs while parked in FULL.
    i_write_full = 1'b1;
    i_start      = 1'b1;
    @(negedge clk);
    i_write_full = 1'b0;
    i_start      = 1'b0;

    nreads = (rst_at_read > 0) ? rst_at_read : fill;
    for (int i = 0; i < nreads; i++) push(K_READ, (start + i) % DEPTH, 0);
    hold = (rst_at_read > 0) ? 1 : int'($urandom_range(fill, 1));

    i_read_req = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      i_start = 1'($urandom_range(1, 0));
    end
    i_read_req = 1'b0;

    if (rst_at_read > 0) begin
      repeat (rst_at_read - 1) @(negedge clk);
      i_start = 1'b1;
      i_rst   = 1'b1;
      @(negedge clk);
      i_rst   = 1'b0;
      i_start = 1'b0;
      check_idle("reset_mid_read");
    end else begin
      i_start = 1'b0;
      repeat (fill - hold + 1) @(negedge clk);
      check_quiet("idle_after_read");
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_write_full = 1'b0; i_mode = 1'b0; i_read_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    i_rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_release");
    mon_en = 1'b1;

    capture(1'b0, 0, 0);    // one-shot, fills all 8
    capture(1'b0, 4, 0);    // one-shot, stopped on 4th write
    capture(1'b1, 11, 0);   // circular, wraps, oldest-first readback
    capture(1'b1, 11, 2);   // reset during 2nd read cycle
    capture(1'b0, 0, 0);    // clean restart after reset
    capture(1'b0, 1, 0);    // single-word capture
    capture(1'b1, 8, 0);    // stop coincides with wrap point
    capture(1'b1, 9, 0);
    capture(1'b0, 8, 0);    // stop coincides with end of one-shot
    capture(1'b0, 10, 0);   // stop arrives only after one-shot ended

    for (int t = 0; t < 25; t++) begin
      bit m;
      int k;
      m = 1'($urandom_range(1, 0));
      k = m ? int'($urandom_range(20, 1)) : int'($urandom_range(11, 0));
      capture(m, k, (t % 7 == 3) ? int'($urandom_range(2, 1)) : 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_ctrl_fsm.md
RAM_CTRL_FSM -- requirements
Module: ram_ctrl_fsm

Interface
REQ-001 Parameter DEPTH, default 8, number of RAM words controlled; legal range 2..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 3, address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  one-cycle start pulse from edge detector; begins a capture.
REQ-006 i_write_full  in  1  external stop; ends capture.
REQ-007 i_mode  in  1  0 = one-shot fill, 1 = circular, wrap until stopped; sampled only in IDLE on i_start.
REQ-008 i_read_req  in  1  level or pulse; starts readback from FULL.
REQ-009 o_write_ena  out  1  RAM write strobe for o_addr this cycle.
REQ-010 o_read_ena  out  1  RAM read strobe for o_addr this cycle.
REQ-011 o_addr  out  ADDR_W  current RAM address.
REQ-012 o_full_mem_indicator  out  1  high while in FULL.
REQ-013 o_fill_cnt  out  ADDR_W+1  number of valid words captured, 0..DEPTH.
REQ-014 o_busy  out  1  high in WRITE or READ.

Function
REQ-015 States: IDLE, WRITE, FULL, READ; all outputs registered, Moore-style, functions of state and counters only.
REQ-016 IDLE: i_start=1 -> WRITE next cycle; o_addr=0, o_fill_cnt=0, latched mode=i_mode.
REQ-017 WRITE: o_write_ena=1 every cycle; o_addr +1 per cycle; o_fill_cnt +1 per cycle, saturating at DEPTH.
REQ-018 WRITE, i_write_full=1: current write still occurs; next state FULL; i_write_full has priority over wrap/end.
REQ-019 WRITE, mode 0, o_addr=DEPTH-1: last write occurs; next state FULL with o_fill_cnt=DEPTH.
REQ-020 WRITE, mode 1, o_addr=DEPTH-1: o_addr wraps to 0, stay in WRITE, set internal wrapped flag.
REQ-021 Address arithmetic is modulo DEPTH, not 2**ADDR_W, for non-power-of-two DEPTH.
REQ-022 FULL: o_write_ena=0, o_read_ena=0, o_full_mem_indicator=1; o_addr and o_fill_cnt hold.
REQ-023 FULL, i_read_req=1 -> READ; start address 0 if not wrapped, else the next write address (oldest word).
REQ-024 READ: o_read_ena=1 for exactly o_fill_cnt consecutive cycles; o_addr +1 mod DEPTH each cycle; then IDLE.
REQ-025 i_start ignored outside IDLE; i_read_req ignored outside FULL; i_write_full ignored outside WRITE.
REQ-026 FULL with o_fill_cnt=0 is unreachable; WRITE always writes at least one word.
REQ-027 At most one of o_write_ena, o_read_ena high in any cycle.

Reset
REQ-028 i_rst=1 at any clock edge, including mid-WRITE or mid-READ -> IDLE next cycle.
REQ-029 Reset values: o_write_ena=0, o_read_ena=0, o_addr=0, o_full_mem_indicator=0, o_fill_cnt=0, o_busy=0, wrapped flag=0, latched mode=0.
REQ-030 i_rst overrides all other inputs in the same cycle.

Structure
REQ-031 Shared package ram_ctrl_pkg holds state encoding typedef (IDLE, WRITE, FULL, READ) and default DEPTH/ADDR_W constants.
REQ-032 One sub-module, addr_ctr: modulo-DEPTH counter with sync clear, load and increment, used for o_addr.
REQ-033 Fill counter and wrapped flag stay in ram_ctrl_fsm.

Verification (DEPTH=8, ADDR_W=3)
REQ-034 Reset held 2 cycles, then released with inputs 0 -> all outputs 0, state IDLE.
REQ-035 i_start, mode 0, no stop -> o_write_ena 8 cycles, addr 0..7, then o_full_mem_indicator=1, o_fill_cnt=8.
REQ-036 i_start, mode 0, i_write_full on 4th write cycle -> writes addr 0..3, FULL, o_fill_cnt=4; i_read_req -> o_read_ena 4 cycles, addr 0..3, then IDLE.
REQ-037 i_start, mode 1, stop after 11 writes -> addr wraps 7->0, o_fill_cnt=8; read addr 3,4,5,6,7,0,1,2.
REQ-038 i_rst pulse mid-READ, 2nd read cycle -> IDLE next cycle, all outputs at reset values; a new i_start starts cleanly at addr 0.
REQ-039 i_start and i_read_req pulsed during WRITE -> no effect; write sequence and counts unchanged.
